// File: rtl/lc3_ctrl_pkg.sv
// rtl/lc3_ctrl_pkg.sv - LC-3 sequencer state codes, opcodes and datapath select encodings
package lc3_ctrl_pkg;

  typedef logic [4:0] state_t;

  localparam state_t S_IDLE      = 5'd0;
  localparam state_t S_FETCH_MAR = 5'd1;
  localparam state_t S_FETCH_PC  = 5'd2;
  localparam state_t S_FETCH_MEM = 5'd3;
  localparam state_t S_FETCH_IR  = 5'd4;
  localparam state_t S_DECODE    = 5'd5;
  localparam state_t S_ALU       = 5'd6;
  localparam state_t S_LEA       = 5'd7;
  localparam state_t S_BR        = 5'd8;
  localparam state_t S_JMP       = 5'd9;
  localparam state_t S_JSR       = 5'd10;
  localparam state_t S_ADDR      = 5'd11;
  localparam state_t S_IND_MEM   = 5'd12;
  localparam state_t S_IND_MAR   = 5'd13;
  localparam state_t S_DATA_MEM  = 5'd14;
  localparam state_t S_LD_REG    = 5'd15;
  localparam state_t S_ST_MDR    = 5'd16;
  localparam state_t S_ST_MEM    = 5'd17;
  localparam state_t S_HALT      = 5'd18;
  localparam state_t S_ERR       = 5'd19;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] ALUK_NOT   = 2'd0;
  localparam logic [1:0] ALUK_AND   = 2'd1;
  localparam logic [1:0] ALUK_ADD   = 2'd2;
  localparam logic [1:0] ALUK_PASSA = 2'd3;

  localparam logic [1:0] A2M_OFF11 = 2'd0;
  localparam logic [1:0] A2M_OFF9  = 2'd1;
  localparam logic [1:0] A2M_OFF6  = 2'd2;
  localparam logic [1:0] A2M_ZERO  = 2'd3;

  localparam logic [1:0] PCMUX_ADDER = 2'd0;
  localparam logic [1:0] PCMUX_BUS   = 2'd1;
  localparam logic [1:0] PCMUX_INC   = 2'd2;

  localparam int CC_N = 2;
  localparam int CC_Z = 1;
  localparam int CC_P = 0;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH_MEM) || (s == S_IND_MEM) || (s == S_DATA_MEM) || (s == S_ST_MEM);
  endfunction

  function automatic logic [1:0] alu_op(input logic [3:0] opcode);
    case (opcode)
      OP_ADD:  return ALUK_ADD;
      OP_AND:  return ALUK_AND;
      default: return ALUK_NOT;
    endcase
  endfunction

endpackage

// File: rtl/lc3_mem_wait.sv
// rtl/lc3_mem_wait.sv - mem_ready handshake with consecutive-wait timeout counter
// start is held high for every cycle spent in a memory state.
module lc3_mem_wait #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic mem_ready,
  output logic done,
  output logic timeout
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam int CNT_W = (TMO_W > 0) ? TMO_W : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done = start & mem_ready;
  // Ready on the limit cycle completes the access; only a low limit cycle times out.
  assign timeout = (MEM_TIMEOUT != 0) & start & ~mem_ready & (cnt_q == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    cnt_d = '0;
    if (start && !mem_ready && !timeout) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lc3_seq_ctrl.sv
// rtl/lc3_seq_ctrl.sv - LC-3 clocked control sequencer owning every datapath strobe
// Define LC3_CTRL_JSR_EN to execute opcode 0100 as JSR/JSRR; otherwise it is illegal.
module lc3_seq_ctrl
  import lc3_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic [2:0]  cc,
  input  logic        mem_ready,
  output logic        ld_ir,
  output logic        ld_reg,
  output logic        gate_alu,
  output logic        a1m_sel,
  output logic        ld_pc,
  output logic        gate_pc,
  output logic        marmux_sel,
  output logic        gate_marmux,
  output logic        ld_cc,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        mem_en,
  output logic        mem_rw,
  output logic        gate_mdr,
  output logic [2:0]  dr,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic [1:0]  aluk,
  output logic [1:0]  a2m_sel,
  output logic [1:0]  pcmux_sel,
  output logic        instr_done,
  output logic        halted,
  output logic        err,
  output logic [4:0]  state
);

  state_t     state_q, state_d, next_instr;
  logic [3:0] opcode;
  logic       mem_done, mem_timeout, br_taken, base_rel, unused_ir;

  assign opcode     = ir[15:12];
  assign unused_ir  = ^ir[5:3];
  assign br_taken   = (ir[11] & cc[CC_N]) | (ir[10] & cc[CC_Z]) | (ir[9] & cc[CC_P]);
  assign base_rel   = (opcode == OP_LDR) || (opcode == OP_STR);
  assign next_instr = run ? S_FETCH_MAR : S_IDLE;
  assign state      = state_q;
  assign halted     = (state_q == S_HALT);
  assign err        = (state_q == S_ERR);

  lc3_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (is_mem_state(state_q)),
    .mem_ready (mem_ready),
    .done      (mem_done),
    .timeout   (mem_timeout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (run) state_d = S_FETCH_MAR;
      S_FETCH_MAR: state_d = S_FETCH_PC;
      S_FETCH_PC:  state_d = S_FETCH_MEM;
      S_FETCH_MEM: if (mem_done) state_d = S_FETCH_IR; else if (mem_timeout) state_d = S_ERR;
      S_FETCH_IR:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT:                   state_d = S_ALU;
          OP_LEA:                                   state_d = S_LEA;
          OP_BR:                                    state_d = S_BR;
          OP_JMP:                                   state_d = S_JMP;
`ifdef LC3_CTRL_JSR_EN
          OP_JSR:                                   state_d = S_JSR;
`else
          OP_JSR:                                   state_d = S_ERR;
`endif
          OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: state_d = S_ADDR;
          OP_TRAP:                                  state_d = S_HALT;
          default:                                  state_d = S_ERR;
        endcase
      end
      S_ALU, S_LEA, S_BR, S_JMP, S_JSR, S_LD_REG: state_d = next_instr;
      S_ADDR: begin
        if (opcode == OP_LDI || opcode == OP_STI)     state_d = S_IND_MEM;
        else if (opcode == OP_LD || opcode == OP_LDR) state_d = S_DATA_MEM;
        else                                          state_d = S_ST_MDR;
      end
      S_IND_MEM:  if (mem_done) state_d = S_IND_MAR; else if (mem_timeout) state_d = S_ERR;
      S_IND_MAR:  state_d = (opcode == OP_LDI) ? S_DATA_MEM : S_ST_MDR;
      S_DATA_MEM: if (mem_done) state_d = S_LD_REG; else if (mem_timeout) state_d = S_ERR;
      S_ST_MDR:   state_d = S_ST_MEM;
      S_ST_MEM:   if (mem_done) state_d = next_instr; else if (mem_timeout) state_d = S_ERR;
      S_HALT, S_ERR: state_d = state_q;
      default:    state_d = S_ERR;
    endcase
  end

  always_comb begin
    {ld_ir, ld_reg, gate_alu, a1m_sel, ld_pc, gate_pc, marmux_sel, gate_marmux} = '0;
    {ld_cc, ld_mar, ld_mdr, mem_en, mem_rw, gate_mdr, instr_done} = '0;
    dr        = 3'd0;
    sr1       = 3'd0;
    sr2       = 3'd0;
    aluk      = ALUK_NOT;
    a2m_sel   = A2M_OFF11;
    pcmux_sel = PCMUX_ADDER;
    case (state_q)
      S_FETCH_MAR: begin gate_pc = 1'b1; ld_mar = 1'b1; end
      S_FETCH_PC:  begin pcmux_sel = PCMUX_INC; ld_pc = 1'b1; end
      S_FETCH_MEM, S_IND_MEM, S_DATA_MEM: begin mem_en = 1'b1; ld_mdr = 1'b1; end
      S_FETCH_IR:  begin gate_mdr = 1'b1; ld_ir = 1'b1; end
      S_ALU: begin
        sr1 = ir[8:6]; sr2 = ir[2:0]; dr = ir[11:9]; aluk = alu_op(opcode);
        gate_alu = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1; instr_done = 1'b1;
      end
      S_LEA: begin
        a1m_sel = 1'b1; a2m_sel = A2M_OFF9; marmux_sel = 1'b1; gate_marmux = 1'b1;
        dr = ir[11:9]; ld_reg = 1'b1; instr_done = 1'b1;
      end
      S_BR: begin
        instr_done = 1'b1;
        if (br_taken) begin a1m_sel = 1'b1; a2m_sel = A2M_OFF9; ld_pc = 1'b1; end
      end
      S_JMP: begin sr1 = ir[8:6]; a2m_sel = A2M_ZERO; ld_pc = 1'b1; instr_done = 1'b1; end
      // R7 takes the bus (old PC) while PC takes the adder, so JSRR R7 sees the old R7.
      S_JSR: begin
        gate_pc = 1'b1; ld_reg = 1'b1; dr = 3'd7; ld_pc = 1'b1; instr_done = 1'b1;
        if (ir[11]) begin a1m_sel = 1'b1; a2m_sel = A2M_OFF11; end
        else begin sr1 = ir[8:6]; a2m_sel = A2M_ZERO; end
      end
      S_ADDR: begin
        marmux_sel = 1'b1; gate_marmux = 1'b1; ld_mar = 1'b1;
        if (base_rel) begin sr1 = ir[8:6]; a2m_sel = A2M_OFF6; end
        else begin a1m_sel = 1'b1; a2m_sel = A2M_OFF9; end
      end
      S_IND_MAR: begin gate_mdr = 1'b1; ld_mar = 1'b1; end
      S_LD_REG: begin
        gate_mdr = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1; dr = ir[11:9]; instr_done = 1'b1;
      end
      S_ST_MDR: begin sr1 = ir[11:9]; aluk = ALUK_PASSA; gate_alu = 1'b1; ld_mdr = 1'b1; end
      S_ST_MEM: begin mem_en = 1'b1; mem_rw = 1'b1; instr_done = mem_done; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_lc3_seq_ctrl.sv
// tb/tb_lc3_seq_ctrl.sv - scoreboard bench: behavioural datapath and memory around lc3_seq_ctrl
module tb_lc3_seq_ctrl;
  import lc3_ctrl_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, mem_ready;
  logic [15:0] ir_m;
  logic [2:0]  cc_m;
  logic ld_ir, ld_reg, gate_alu, a1m_sel, ld_pc, gate_pc, marmux_sel, gate_marmux;
  logic ld_cc, ld_mar, ld_mdr, mem_en, mem_rw, gate_mdr, instr_done, halted, err;
  logic [2:0] dr, sr1, sr2;
  logic [1:0] aluk, a2m_sel, pcmux_sel;
  logic [4:0] state;

  lc3_seq_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ir(ir_m), .cc(cc_m), .mem_ready(mem_ready),
    .ld_ir(ld_ir), .ld_reg(ld_reg), .gate_alu(gate_alu), .a1m_sel(a1m_sel), .ld_pc(ld_pc),
    .gate_pc(gate_pc), .marmux_sel(marmux_sel), .gate_marmux(gate_marmux), .ld_cc(ld_cc),
    .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mem_en(mem_en), .mem_rw(mem_rw), .gate_mdr(gate_mdr),
    .dr(dr), .sr1(sr1), .sr2(sr2), .aluk(aluk), .a2m_sel(a2m_sel), .pcmux_sel(pcmux_sel),
    .instr_done(instr_done), .halted(halted), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Datapath and memory model
  logic [15:0] pc_m, mar_m, mdr_m;
  logic [15:0] rf [8];
  logic [15:0] mem [65536];
  logic [15:0] init_rf [8];
  logic [2:0]  init_cc;
  logic        tb_we = 1'b0;
  logic [15:0] tb_wa, tb_wd;
  logic [15:0] a1, a2, sum, alu_b, alu_y, bus, pc_next;
  int          wait_w = 0, wcnt = 0;
  logic        stuck = 1'b0;

  assign mem_ready = mem_en && !stuck && (wcnt >= wait_w);

  always @(posedge clk) begin
    if (!mem_en || mem_ready) wcnt <= 0;
    else                      wcnt <= wcnt + 1;
  end

  always_comb begin
    a1 = a1m_sel ? pc_m : rf[sr1];
    case (a2m_sel)
      2'd0:    a2 = {{5{ir_m[10]}}, ir_m[10:0]};
      2'd1:    a2 = {{7{ir_m[8]}}, ir_m[8:0]};
      2'd2:    a2 = {{10{ir_m[5]}}, ir_m[5:0]};
      default: a2 = 16'h0000;
    endcase
    sum   = a1 + a2;
    alu_b = ir_m[5] ? {{11{ir_m[4]}}, ir_m[4:0]} : rf[sr2];
    case (aluk)
      2'd0:    alu_y = ~rf[sr1];
      2'd1:    alu_y = rf[sr1] & alu_b;
      2'd2:    alu_y = rf[sr1] + alu_b;
      default: alu_y = rf[sr1];
    endcase
    bus = gate_pc ? pc_m : gate_alu ? alu_y : gate_marmux ? sum : gate_mdr ? mdr_m : 16'h0000;
    pc_next = (pcmux_sel == 2'd0) ? sum : (pcmux_sel == 2'd1) ? bus : pc_m + 16'd1;
  end

  always @(posedge clk) begin
    if (tb_we) mem[tb_wa] <= tb_wd;
    if (!rst_n) begin
      pc_m <= 16'h3000; ir_m <= 16'h0; mar_m <= 16'h0; mdr_m <= 16'h0; cc_m <= init_cc;
      for (int i = 0; i < 8; i++) rf[i] <= init_rf[i];
    end else begin
      if (ld_pc)  pc_m <= pc_next;
      if (ld_ir)  ir_m <= bus;
      if (ld_reg) rf[dr] <= bus;
      if (ld_cc)  cc_m <= bus[15] ? 3'b100 : (bus == 16'h0) ? 3'b010 : 3'b001;
      if (ld_mar) mar_m <= bus;
      if (ld_mdr) begin
        if (!mem_en)        mdr_m <= bus;
        else if (mem_ready) mdr_m <= mem[mar_m];
      end
      if (mem_en && mem_rw && mem_ready) mem[mar_m] <= mdr_m;
    end
  end

  // Scoreboard
  typedef struct {
    string       tag;
    int          lat;
    logic [15:0] pc;
    int          rd;
    logic [15:0] rv;
    int          ma;
    logic [15:0] mv;
    logic [2:0]  cc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0, t0 = 0, lat_seen = 0;
  bit   pend = 1'b0;

  task automatic expect_instr(input string tag, input int lat, input logic [15:0] pc,
                              input int rd, input logic [15:0] rv, input int ma,
                              input logic [15:0] mv, input logic [2:0] cc);
    exp_t x;
    x.tag = tag; x.lat = lat; x.pc = pc; x.rd = rd; x.rv = rv; x.ma = ma; x.mv = mv; x.cc = cc;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (pend) begin
      pend = 1'b0;
      if (sb.size() == 0) check("sb_unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        check({e.tag, "_lat"}, lat_seen, e.lat);
        check({e.tag, "_pc"}, pc_m, e.pc);
        if (e.rd >= 0) check({e.tag, "_reg"}, rf[e.rd[2:0]], e.rv);
        if (e.ma >= 0) check({e.tag, "_mem"}, mem[e.ma[15:0]], e.mv);
        check({e.tag, "_cc"}, cc_m, e.cc);
      end
    end
    if (state == S_FETCH_MAR) t0 = cyc;
    if (instr_done) begin
      lat_seen = cyc - t0 + 1;
      pend = 1'b1;
    end
  end

  function automatic logic [29:0] strobes();
    return {ld_ir, ld_reg, gate_alu, a1m_sel, ld_pc, gate_pc, marmux_sel, gate_marmux,
            ld_cc, ld_mar, ld_mdr, mem_en, mem_rw, gate_mdr, dr, sr1, sr2, aluk,
            a2m_sel, pcmux_sel, instr_done};
  endfunction

  task automatic setup(input int w, input logic [2:0] cc0);
    rst_n = 1'b0; run = 1'b0; stuck = 1'b0; wait_w = w; init_cc = cc0;
    for (int i = 0; i < 8; i++) init_rf[i] = 16'h0;
    @(negedge clk);
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    tb_wa = a; tb_wd = d; tb_we = 1'b1;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic go();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_run();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic wait_state(input logic [4:0] s, input int budget, input string tag);
    int n = 0;
    while (state != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, state, s);
  endtask

  task automatic run_one(input string tag);
    pulse_run();
    wait_state(S_IDLE, 80, {tag, "_park"});
    @(negedge clk);
  endtask

  initial begin
    int n;
    // Reset state
    setup(0, 3'b000);
    go();
    #2 rst_n = 1'b0;
    #1;
    check("rst_state", state, S_IDLE);
    check("rst_strobes", strobes(), 30'h0);
    check("rst_flags", {halted, err}, 2'b00);

    // ADD R1,R2,R3 with no wait states
    setup(0, 3'b000);
    init_rf[2] = 16'd5; init_rf[3] = 16'd7;
    poke(16'h3000, 16'h1283);
    go();
    expect_instr("add_w0", 6, 16'h3001, 1, 16'd12, -1, 16'h0, 3'b001);
    run_one("add_w0");

    // Four wait states on fetch: ready on the limit cycle still completes
    setup(4, 3'b000);
    init_rf[2] = 16'd5; init_rf[3] = 16'd7;
    poke(16'h3000, 16'h1283);
    go();
    expect_instr("add_w4", 10, 16'h3001, 1, 16'd12, -1, 16'h0, 3'b001);
    run_one("add_w4");
    check("add_w4_no_err", err, 1'b0);

    // LDI R4 via pointer at x3002 -> x4000 -> x8000, two waits per access
    setup(2, 3'b000);
    poke(16'h3000, 16'hA801); poke(16'h3002, 16'h4000); poke(16'h4000, 16'h8000);
    go();
    expect_instr("ldi_w2", 16, 16'h3001, 4, 16'h8000, -1, 16'h0, 3'b100);
    run_one("ldi_w2");

    // LD R0 from x3003 = 0, one wait per access
    setup(1, 3'b001);
    init_rf[0] = 16'h1234;
    poke(16'h3000, 16'h2002); poke(16'h3003, 16'h0000);
    go();
    expect_instr("ld_w1", 10, 16'h3001, 0, 16'h0000, -1, 16'h0, 3'b010);
    run_one("ld_w1");

    // BRz not taken, then BRz -2 taken
    setup(0, 3'b001);
    poke(16'h3000, 16'h0405);
    go();
    expect_instr("brz_nt", 6, 16'h3001, -1, 16'h0, -1, 16'h0, 3'b001);
    run_one("brz_nt");
    setup(0, 3'b010);
    poke(16'h3000, 16'h05FE);
    go();
    expect_instr("brz_t", 6, 16'h2FFF, -1, 16'h0, -1, 16'h0, 3'b010);
    run_one("brz_t");

    // STR R5,R6,#2 with run dropped mid-execute
    setup(0, 3'b001);
    init_rf[5] = 16'hBEEF; init_rf[6] = 16'h4000;
    poke(16'h3000, 16'h7B82); poke(16'h4002, 16'h0000);
    go();
    expect_instr("str_stop", 8, 16'h3001, -1, 16'h0, 16'h4002, 16'hBEEF, 3'b001);
    @(negedge clk); run = 1'b1;
    wait_state(S_ST_MDR, 20, "str_reach_st_mdr");
    run = 1'b0;
    wait_state(S_IDLE, 20, "str_park");
    repeat (3) @(negedge clk);
    check("str_stays_idle", state, S_IDLE);

    // JSRR R7 with R7 = x5000
    setup(0, 3'b001);
    init_rf[7] = 16'h5000;
    poke(16'h3000, 16'h41C0);
    go();
`ifdef LC3_CTRL_JSR_EN
    expect_instr("jsrr_r7", 6, 16'h5000, 7, 16'h3001, -1, 16'h0, 3'b001);
    run_one("jsrr_r7");
`else
    pulse_run();
    wait_state(S_ERR, 20, "jsr_off_state");
    check("jsr_off_err", err, 1'b1);
`endif

    // mem_ready stuck low: five cycles of mem_en (first + four waits), then ERR
    setup(0, 3'b000);
    poke(16'h3000, 16'h1283);
    go();
    stuck = 1'b1;
    pulse_run();
    wait_state(S_FETCH_MEM, 10, "tmo_enter");
    n = 0;
    while (mem_en && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("tmo_mem_en_cycles", n, 5);
    check("tmo_state", state, S_ERR);
    check("tmo_flags", {halted, err}, 2'b01);
    check("tmo_strobes", strobes(), 30'h0);
    stuck = 1'b0;
    repeat (5) @(negedge clk);
    check("tmo_err_held", state, S_ERR);
    #2 rst_n = 1'b0;
    #1;
    check("tmo_reset_clears", {state, err}, {S_IDLE, 1'b0});

    // Illegal opcode 1101
    setup(0, 3'b000);
    poke(16'h3000, 16'hD000);
    go();
    pulse_run();
    wait_state(S_ERR, 20, "ill_state");
    check("ill_err", err, 1'b1);

    // TRAP halts
    setup(0, 3'b000);
    poke(16'h3000, 16'hF025);
    go();
    pulse_run();
    wait_state(S_HALT, 20, "trap_state");
    repeat (3) @(negedge clk);
    check("trap_flags", {state, halted, err}, {S_HALT, 2'b10});
    check("trap_strobes", strobes(), 30'h0);

    // Reset asserted mid-access drops mem_en without a clock edge
    setup(0, 3'b000);
    poke(16'h3000, 16'h1283);
    go();
    stuck = 1'b1;
    pulse_run();
    wait_state(S_FETCH_MEM, 10, "rstmid_enter");
    check("rstmid_mem_en_before", mem_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_mem_en", mem_en, 1'b0);
    check("rstmid_state", state, S_IDLE);
    stuck = 1'b0;

    @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
